// File: rtl/write_back_stage_pkg.sv
// Shared encodings for the write-back stage: destination select, data-source
// select, load size and the default link-register index.
package write_back_stage_pkg;

    localparam int RA_REG_DEFAULT = 31;

    typedef enum logic [1:0] {
        REG_DST_RT     = 2'b00,
        REG_DST_RD     = 2'b01,
        REG_DST_RA     = 2'b10,
        REG_DST_RD_ALT = 2'b11
    } reg_dst_e;

    typedef enum logic [1:0] {
        MEM_TO_REG_ALU     = 2'b00,
        MEM_TO_REG_LOAD    = 2'b01,
        MEM_TO_REG_LINK    = 2'b10,
        MEM_TO_REG_ALU_ALT = 2'b11
    } mem_to_reg_e;

    typedef enum logic [1:0] {
        LOAD_BYTE     = 2'b00,
        LOAD_HALF     = 2'b01,
        LOAD_WORD     = 2'b10,
        LOAD_WORD_ALT = 2'b11
    } load_size_e;

    // Sign bit to replicate above a narrow load; zero when zero-extending.
    function automatic logic ext_bit(input logic msb, input logic load_unsigned);
        return msb & ~load_unsigned;
    endfunction

endpackage

// File: rtl/write_back_stage_if.sv
// MEM/WB entry and write-back result bundle. The master side is the MEM stage
// (drives the entry), the slave side is the write-back stage.
interface write_back_stage_if #(
    parameter int NB_DATA        = 32,
    parameter int NB_REG_ADDRESS = 5
);
    logic                      i_valid;
    logic                      i_stall;
    logic                      i_flush;
    logic [NB_DATA-1:0]        i_alu_result;
    logic [NB_DATA-1:0]        i_mem_data;
    logic [NB_DATA-1:0]        i_pc_link;
    logic [NB_REG_ADDRESS-1:0] i_rt;
    logic [NB_REG_ADDRESS-1:0] i_rd;
    logic [1:0]                i_reg_dst;
    logic [1:0]                i_mem_to_reg;
    logic [1:0]                i_load_size;
    logic                      i_load_unsigned;
    logic [1:0]                i_byte_offset;
    logic                      i_reg_write;

    logic [NB_DATA-1:0]        o_dato;
    logic [NB_REG_ADDRESS-1:0] o_direccion;
    logic                      o_reg_write;
    logic                      o_valid;

    modport master (
        output i_valid, i_stall, i_flush, i_alu_result, i_mem_data, i_pc_link,
               i_rt, i_rd, i_reg_dst, i_mem_to_reg, i_load_size, i_load_unsigned,
               i_byte_offset, i_reg_write,
        input  o_dato, o_direccion, o_reg_write, o_valid
    );

    modport slave (
        input  i_valid, i_stall, i_flush, i_alu_result, i_mem_data, i_pc_link,
               i_rt, i_rd, i_reg_dst, i_mem_to_reg, i_load_size, i_load_unsigned,
               i_byte_offset, i_reg_write,
        output o_dato, o_direccion, o_reg_write, o_valid
    );
endinterface

// File: rtl/write_back_stage_load_extender.sv
// Combinational load alignment: picks the byte/halfword/word out of the aligned
// memory word (little-endian) and zero- or sign-extends it to NB_DATA.
module load_extender
    import write_back_stage_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic [NB_DATA-1:0] mem_data,
    input  logic [1:0]         byte_offset,
    input  load_size_e         load_size,
    input  logic               load_unsigned,
    output logic [NB_DATA-1:0] load_value
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = mem_data[gi*8 +: 8];
        end
    endgenerate

    assign byte_sel = byte_lane[byte_offset];
    // Halfword alignment only looks at offset[1]; offset[0] is don't-care.
    assign half_sel = byte_offset[1] ? mem_data[31:16] : mem_data[15:0];

    always_comb begin
        load_value = '0;
        case (load_size)
            LOAD_BYTE: begin
                load_value       = {NB_DATA{ext_bit(byte_sel[7], load_unsigned)}};
                load_value[7:0]  = byte_sel;
            end
            LOAD_HALF: begin
                load_value       = {NB_DATA{ext_bit(half_sel[15], load_unsigned)}};
                load_value[15:0] = half_sel;
            end
            default: begin
                load_value       = '0;
                load_value[31:0] = mem_data[31:0];
            end
        endcase
    end

endmodule

// File: rtl/write_back_stage.sv
// MEM/WB pipeline register plus write-back muxing. Optional retired-instruction
// counter (o_retired) is built when WB_RETIRE_COUNT_EN is defined.
module write_back_stage
    import write_back_stage_pkg::*;
#(
    parameter int NB_DATA        = 32,
    parameter int NB_REG_ADDRESS = 5,
    parameter int RA_REG         = RA_REG_DEFAULT
) (
    input  logic                i_clock,
    input  logic                i_reset,
`ifdef WB_RETIRE_COUNT_EN
    output logic [31:0]         o_retired,
`endif
    write_back_stage_if.slave   wb
);

    logic                      valid_reg;
    logic [NB_DATA-1:0]        alu_result_reg;
    logic [NB_DATA-1:0]        mem_data_reg;
    logic [NB_DATA-1:0]        pc_link_reg;
    logic [NB_REG_ADDRESS-1:0] rt_reg;
    logic [NB_REG_ADDRESS-1:0] rd_reg;
    reg_dst_e                  reg_dst_reg;
    mem_to_reg_e               mem_to_reg_reg;
    load_size_e                load_size_reg;
    logic                      load_unsigned_reg;
    logic [1:0]                byte_offset_reg;
    logic                      reg_write_reg;

    logic [NB_DATA-1:0]        load_value;
    logic [NB_DATA-1:0]        dato_next;
    logic [NB_REG_ADDRESS-1:0] direccion_next;

    // Reset and flush both load an all-zero bubble; flush wins over stall.
    always_ff @(posedge i_clock) begin
        if (i_reset || wb.i_flush) begin
            valid_reg         <= 1'b0;
            alu_result_reg    <= '0;
            mem_data_reg      <= '0;
            pc_link_reg       <= '0;
            rt_reg            <= '0;
            rd_reg            <= '0;
            reg_dst_reg       <= REG_DST_RT;
            mem_to_reg_reg    <= MEM_TO_REG_ALU;
            load_size_reg     <= LOAD_BYTE;
            load_unsigned_reg <= 1'b0;
            byte_offset_reg   <= '0;
            reg_write_reg     <= 1'b0;
        end else if (!wb.i_stall) begin
            valid_reg         <= wb.i_valid;
            alu_result_reg    <= wb.i_alu_result;
            mem_data_reg      <= wb.i_mem_data;
            pc_link_reg       <= wb.i_pc_link;
            rt_reg            <= wb.i_rt;
            rd_reg            <= wb.i_rd;
            reg_dst_reg       <= reg_dst_e'(wb.i_reg_dst);
            mem_to_reg_reg    <= mem_to_reg_e'(wb.i_mem_to_reg);
            load_size_reg     <= load_size_e'(wb.i_load_size);
            load_unsigned_reg <= wb.i_load_unsigned;
            byte_offset_reg   <= wb.i_byte_offset;
            reg_write_reg     <= wb.i_reg_write;
        end
    end

    load_extender #(
        .NB_DATA (NB_DATA)
    ) u_load_extender (
        .mem_data      (mem_data_reg),
        .byte_offset   (byte_offset_reg),
        .load_size     (load_size_reg),
        .load_unsigned (load_unsigned_reg),
        .load_value    (load_value)
    );

    always_comb begin
        dato_next = alu_result_reg;
        case (mem_to_reg_reg)
            MEM_TO_REG_LOAD: dato_next = load_value;
            MEM_TO_REG_LINK: dato_next = pc_link_reg;
            default:         dato_next = alu_result_reg;
        endcase
    end

    always_comb begin
        direccion_next = rd_reg;
        case (reg_dst_reg)
            REG_DST_RT: direccion_next = rt_reg;
            REG_DST_RA: direccion_next = NB_REG_ADDRESS'(RA_REG);
            default:    direccion_next = rd_reg;
        endcase
    end

    assign wb.o_dato      = dato_next;
    assign wb.o_direccion = direccion_next;
    assign wb.o_valid     = valid_reg;
    // Register 0 is hard-wired, so a write to it is suppressed here.
    assign wb.o_reg_write = reg_write_reg & valid_reg & (direccion_next != '0);

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retired_reg;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            retired_reg <= '0;
        end else if (valid_reg && !wb.i_stall) begin
            retired_reg <= retired_reg + 32'd1;
        end
    end

    assign o_retired = retired_reg;
`endif

endmodule
